// File: rtl/pll_dyn_ctrl.sv
// Reset/lock sequencer and dynamic divider-select controller for the GW2A rPLL (720p pixel clock).
// Define PLL_LOSS_CNT_EN to build the saturating RUN lock-loss counter on loss_cnt.
module pll_dyn_ctrl #(
   parameter logic [5:0] DEF_IDSEL          = 6'd0,
   parameter logic [5:0] DEF_FBDSEL         = 6'd0,
   parameter logic [5:0] DEF_ODSEL          = 6'd0,
   parameter int         RESET_CYCLES       = 16,
   parameter int         LOCK_STABLE_CYCLES = 1024,
   parameter int         LOCK_TIMEOUT       = 65535,
   parameter int         MAX_RETRIES        = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cfg_valid,
   output logic       cfg_ready,
   input  logic [5:0] cfg_idsel,
   input  logic [5:0] cfg_fbdsel,
   input  logic [5:0] cfg_odsel,
   input  logic       pll_lock,
   output logic       pll_reset,
   output logic [5:0] pll_idsel,
   output logic [5:0] pll_fbdsel,
   output logic [5:0] pll_odsel,
   output logic       locked,
   output logic       user_rst,
   output logic       fail,
   output logic [7:0] loss_cnt
);

   localparam int RC_W  = (RESET_CYCLES > 1)       ? $clog2(RESET_CYCLES)       : 1;
   localparam int LS_W  = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
   localparam int LT_W  = (LOCK_TIMEOUT > 1)       ? $clog2(LOCK_TIMEOUT)       : 1;
   localparam int RT_W  = (MAX_RETRIES > 1)        ? $clog2(MAX_RETRIES)        : 1;
   localparam int MX_W  = (RC_W > LS_W) ? RC_W : LS_W;
   localparam int CNT_W = (MX_W > LT_W) ? MX_W : LT_W;

   localparam logic [CNT_W-1:0] RC_LAST = CNT_W'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0] LS_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] LT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [RT_W-1:0]  RT_LAST = RT_W'(MAX_RETRIES - 1);

   typedef enum logic [2:0] {
      ST_HOLD,
      ST_WAIT_LOCK,
      ST_STABLE,
      ST_RUN,
      ST_FAIL
   } state_t;

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [RT_W-1:0]  retry_reg, retry_next;
   logic [5:0]       idsel_reg, idsel_next;
   logic [5:0]       fbdsel_reg, fbdsel_next;
   logic [5:0]       odsel_reg, odsel_next;
   logic             lock_meta_reg, lock_s_reg;
   logic             pll_reset_reg, locked_reg, user_rst_reg, fail_reg, cfg_ready_reg;
   logic             accept;

   assign accept = cfg_valid & cfg_ready_reg;

   // One phase counter is shared by HOLD, WAIT_LOCK and STABLE; it restarts at 0 on every state change.
   always_comb begin
      state_next  = state_reg;
      cnt_next    = cnt_reg + CNT_W'(1);
      retry_next  = retry_reg;
      idsel_next  = idsel_reg;
      fbdsel_next = fbdsel_reg;
      odsel_next  = odsel_reg;
      case (state_reg)
         ST_HOLD: begin
            if (cnt_reg == RC_LAST) begin
               state_next = ST_WAIT_LOCK;
               cnt_next   = '0;
            end
         end
         ST_WAIT_LOCK: begin
            if (lock_s_reg) begin
               state_next = ST_STABLE;
               cnt_next   = '0;
            end else if (cnt_reg == LT_LAST) begin
               cnt_next = '0;
               if (retry_reg == RT_LAST) begin
                  state_next = ST_FAIL;
               end else begin
                  state_next = ST_HOLD;
                  retry_next = retry_reg + RT_W'(1);
               end
            end
         end
         ST_STABLE: begin
            if (!lock_s_reg) begin
               state_next = ST_WAIT_LOCK;
               cnt_next   = '0;
            end else if (cnt_reg == LS_LAST) begin
               state_next = ST_RUN;
               cnt_next   = '0;
               retry_next = '0;
            end
         end
         ST_RUN: begin
            cnt_next = '0;
            if (accept) begin
               idsel_next  = cfg_idsel;
               fbdsel_next = cfg_fbdsel;
               odsel_next  = cfg_odsel;
            end
            if (accept || !lock_s_reg) begin
               state_next = ST_HOLD;
            end
         end
         ST_FAIL: begin
            cnt_next = '0;
            if (accept) begin
               idsel_next  = cfg_idsel;
               fbdsel_next = cfg_fbdsel;
               odsel_next  = cfg_odsel;
               retry_next  = '0;
               state_next  = ST_HOLD;
            end
         end
         default: begin
            state_next = ST_HOLD;
            cnt_next   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lock_meta_reg <= 1'b0;
         lock_s_reg    <= 1'b0;
         state_reg     <= ST_HOLD;
         cnt_reg       <= '0;
         retry_reg     <= '0;
         idsel_reg     <= DEF_IDSEL;
         fbdsel_reg    <= DEF_FBDSEL;
         odsel_reg     <= DEF_ODSEL;
         pll_reset_reg <= 1'b1;
         locked_reg    <= 1'b0;
         user_rst_reg  <= 1'b1;
         fail_reg      <= 1'b0;
         cfg_ready_reg <= 1'b0;
      end else begin
         lock_meta_reg <= pll_lock;
         lock_s_reg    <= lock_meta_reg;
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         retry_reg     <= retry_next;
         idsel_reg     <= idsel_next;
         fbdsel_reg    <= fbdsel_next;
         odsel_reg     <= odsel_next;
         // Outputs are decoded from the next state so they line up with the state register.
         pll_reset_reg <= (state_next == ST_HOLD) || (state_next == ST_FAIL);
         locked_reg    <= (state_next == ST_RUN);
         user_rst_reg  <= (state_next != ST_RUN);
         fail_reg      <= (state_next == ST_FAIL);
         cfg_ready_reg <= (state_next == ST_RUN) || (state_next == ST_FAIL);
      end
   end

`ifdef PLL_LOSS_CNT_EN
   logic [7:0] loss_cnt_reg;
   logic       loss_evt;

   assign loss_evt = (state_reg == ST_RUN) && !lock_s_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         loss_cnt_reg <= 8'd0;
      end else if (loss_evt && (loss_cnt_reg != 8'hFF)) begin
         loss_cnt_reg <= loss_cnt_reg + 8'd1;
      end
   end

   assign loss_cnt = loss_cnt_reg;
`else
   assign loss_cnt = 8'd0;
`endif

   assign pll_reset  = pll_reset_reg;
   assign pll_idsel  = idsel_reg;
   assign pll_fbdsel = fbdsel_reg;
   assign pll_odsel  = odsel_reg;
   assign locked     = locked_reg;
   assign user_rst   = user_rst_reg;
   assign fail       = fail_reg;
   assign cfg_ready  = cfg_ready_reg;

endmodule

// File: tb/tb_pll_dyn_ctrl.sv
// Scoreboard bench for pll_dyn_ctrl: expected output snapshots are queued per target cycle and compared when reached.
// Expected loss_cnt steps follow PLL_LOSS_CNT_EN as the design does.
module tb_pll_dyn_ctrl;

   localparam logic [5:0] D_ID = 6'h01;
   localparam logic [5:0] D_FB = 6'h02;
   localparam logic [5:0] D_OD = 6'h04;
`ifdef PLL_LOSS_CNT_EN
   localparam logic [7:0] LOSS_STEP = 8'd1;
`else
   localparam logic [7:0] LOSS_STEP = 8'd0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cfg_valid = 1'b0;
   logic [5:0] cfg_idsel = 6'd0, cfg_fbdsel = 6'd0, cfg_odsel = 6'd0;
   logic       pll_lock = 1'b0;
   logic       cfg_ready, pll_reset, locked, user_rst, fail;
   logic [5:0] pll_idsel, pll_fbdsel, pll_odsel;
   logic [7:0] loss_cnt;

   pll_dyn_ctrl #(
      .DEF_IDSEL(D_ID), .DEF_FBDSEL(D_FB), .DEF_ODSEL(D_OD),
      .RESET_CYCLES(4), .LOCK_STABLE_CYCLES(8), .LOCK_TIMEOUT(20), .MAX_RETRIES(2)
   ) dut (
      .clk(clk), .rst(rst),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_idsel(cfg_idsel), .cfg_fbdsel(cfg_fbdsel), .cfg_odsel(cfg_odsel),
      .pll_lock(pll_lock), .pll_reset(pll_reset),
      .pll_idsel(pll_idsel), .pll_fbdsel(pll_fbdsel), .pll_odsel(pll_odsel),
      .locked(locked), .user_rst(user_rst), .fail(fail), .loss_cnt(loss_cnt)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic       pll_reset, locked, user_rst, fail, cfg_ready;
      logic [5:0] id, fb, od;
      logic [7:0] loss;
   } outs_t;

   typedef enum {K_HOLD, K_WAIT, K_RUN, K_FAIL} kind_t;

   int         n_pass = 0;
   int         n_total = 0;
   logic [5:0] ev_id = D_ID, ev_fb = D_FB, ev_od = D_OD;
   logic [7:0] ev_loss = 8'd0;

   int    q_cyc[$];
   string q_nm[$];
   outs_t q_val[$];

   // Expected flags per externally visible phase: {pll_reset, locked, user_rst, fail, cfg_ready}.
   function automatic outs_t mk(input kind_t k);
      outs_t o;
      o.id   = ev_id;
      o.fb   = ev_fb;
      o.od   = ev_od;
      o.loss = ev_loss;
      case (k)
         K_HOLD:  {o.pll_reset, o.locked, o.user_rst, o.fail, o.cfg_ready} = 5'b10100;
         K_WAIT:  {o.pll_reset, o.locked, o.user_rst, o.fail, o.cfg_ready} = 5'b00100;
         K_RUN:   {o.pll_reset, o.locked, o.user_rst, o.fail, o.cfg_ready} = 5'b01001;
         default: {o.pll_reset, o.locked, o.user_rst, o.fail, o.cfg_ready} = 5'b10111;
      endcase
      return o;
   endfunction

   function automatic outs_t snap();
      return {pll_reset, locked, user_rst, fail, cfg_ready, pll_idsel, pll_fbdsel, pll_odsel, loss_cnt};
   endfunction

   task automatic push(input int at, input string nm, input kind_t k);
      q_cyc.push_back(at);
      q_nm.push_back(nm);
      q_val.push_back(mk(k));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_cfg(input logic [5:0] id, input logic [5:0] fb, input logic [5:0] od);
      cfg_valid  = 1'b1;
      cfg_idsel  = id;
      cfg_fbdsel = fb;
      cfg_odsel  = od;
   endtask

   task automatic test_reset();
      int t0; int e_at; string e_nm; outs_t e_v, got;
      rst = 1'b1;
      tick();
      t0 = cyc;
      for (int k = 0; k <= 1; k++) begin
         push(t0 + k, "reset_state", K_HOLD);
         while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
            e_at = q_cyc.pop_front(); e_nm = q_nm.pop_front(); e_v = q_val.pop_front();
            got = snap();
            n_total++;
            if (e_at != cyc || got !== e_v)
               $display("FAIL %s cyc=%0d got=%h expected=%h", e_nm, cyc, got, e_v);
            else n_pass++;
         end
         tick();
      end
   endtask

   task automatic test_lock_acquire();
      int t0; int e_at; string e_nm; outs_t e_v, got;
      t0 = cyc;
      for (int k = 0; k <= 22; k++) begin
         if (k == 0) begin
            rst = 1'b0;
            push(t0, "hold_first", K_HOLD);
            push(t0 + 3, "hold_last", K_HOLD);
            push(t0 + 4, "reset_released", K_WAIT);
         end
         if (k == 10) begin
            pll_lock = 1'b1;
            push(t0 + 20, "acq_not_yet_locked", K_WAIT);
            push(t0 + 21, "acq_locked", K_RUN);
         end
         while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
            e_at = q_cyc.pop_front(); e_nm = q_nm.pop_front(); e_v = q_val.pop_front();
            got = snap();
            n_total++;
            if (e_at != cyc || got !== e_v)
               $display("FAIL %s cyc=%0d got=%h expected=%h", e_nm, cyc, got, e_v);
            else n_pass++;
         end
         tick();
      end
   endtask

   task automatic test_reconfig();
      int t0; int e_at; string e_nm; outs_t e_v, got;
      t0 = cyc;
      for (int k = 0; k <= 18; k++) begin
         if (k == 0) begin
            push(t0, "run_before_cfg", K_RUN);
            set_cfg(6'h15, 6'h2A, 6'h07);
            ev_id = 6'h15; ev_fb = 6'h2A; ev_od = 6'h07;
            push(t0 + 1, "cfg_hold_new_sel", K_HOLD);
            push(t0 + 4, "cfg_hold_last", K_HOLD);
            push(t0 + 5, "cfg_reset_released", K_WAIT);
         end
         if (k == 1) begin
            cfg_valid = 1'b0;
            pll_lock  = 1'b0;
         end
         if (k == 6) begin
            pll_lock = 1'b1;
            push(t0 + 16, "cfg_not_yet_locked", K_WAIT);
            push(t0 + 17, "cfg_relocked", K_RUN);
         end
         while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
            e_at = q_cyc.pop_front(); e_nm = q_nm.pop_front(); e_v = q_val.pop_front();
            got = snap();
            n_total++;
            if (e_at != cyc || got !== e_v)
               $display("FAIL %s cyc=%0d got=%h expected=%h", e_nm, cyc, got, e_v);
            else n_pass++;
         end
         tick();
      end
   endtask

   task automatic test_stable_glitch();
      int t0; int e_at; string e_nm; outs_t e_v, got;
      t0 = cyc;
      for (int k = 0; k <= 25; k++) begin
         if (k == 0) begin
            set_cfg(6'h0A, 6'h0B, 6'h0C);
            ev_id = 6'h0A; ev_fb = 6'h0B; ev_od = 6'h0C;
            push(t0 + 1, "glitch_hold", K_HOLD);
         end
         if (k == 1) begin
            cfg_valid = 1'b0;
            pll_lock  = 1'b0;
         end
         if (k == 6)  pll_lock = 1'b1;
         if (k == 12) pll_lock = 1'b0;
         if (k == 13) begin
            pll_lock = 1'b1;
            push(t0 + 15, "glitch_back_to_wait", K_WAIT);
            push(t0 + 17, "glitch_no_early_lock", K_WAIT);
            push(t0 + 23, "glitch_not_yet_locked", K_WAIT);
            push(t0 + 24, "glitch_relocked", K_RUN);
         end
         while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
            e_at = q_cyc.pop_front(); e_nm = q_nm.pop_front(); e_v = q_val.pop_front();
            got = snap();
            n_total++;
            if (e_at != cyc || got !== e_v)
               $display("FAIL %s cyc=%0d got=%h expected=%h", e_nm, cyc, got, e_v);
            else n_pass++;
         end
         tick();
      end
   endtask

   task automatic test_loss_and_cfg();
      int t0; int e_at; string e_nm; outs_t e_v, got;
      t0 = cyc;
      for (int k = 0; k <= 41; k++) begin
         if (k == 0) begin
            pll_lock = 1'b0;
            push(t0 + 2, "lc_still_run", K_RUN);
         end
         if (k == 2) begin
            set_cfg(6'h21, 6'h22, 6'h23);
            ev_id = 6'h21; ev_fb = 6'h22; ev_od = 6'h23;
            ev_loss = ev_loss + LOSS_STEP;
            push(t0 + 3, "lc_hold_both", K_HOLD);
            push(t0 + 6, "lc_hold_last", K_HOLD);
            push(t0 + 7, "lc_single_hold", K_WAIT);
         end
         if (k == 3) cfg_valid = 1'b0;
         if (k == 8) begin
            pll_lock = 1'b1;
            push(t0 + 18, "lc_not_yet_locked", K_WAIT);
            push(t0 + 19, "lc_relocked", K_RUN);
         end
         if (k == 21) begin
            pll_lock = 1'b0;
            push(t0 + 23, "loss_still_run", K_RUN);
            ev_loss = ev_loss + LOSS_STEP;
            push(t0 + 24, "loss_hold", K_HOLD);
         end
         if (k == 29) begin
            pll_lock = 1'b1;
            push(t0 + 39, "loss_not_yet_locked", K_WAIT);
            push(t0 + 40, "loss_relocked", K_RUN);
         end
         while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
            e_at = q_cyc.pop_front(); e_nm = q_nm.pop_front(); e_v = q_val.pop_front();
            got = snap();
            n_total++;
            if (e_at != cyc || got !== e_v)
               $display("FAIL %s cyc=%0d got=%h expected=%h", e_nm, cyc, got, e_v);
            else n_pass++;
         end
         tick();
      end
   endtask

   task automatic test_fail_retry();
      int t0; int e_at; string e_nm; outs_t e_v, got;
      rst = 1'b1;
      pll_lock = 1'b0;
      tick();
      t0 = cyc;
      for (int k = 0; k <= 65; k++) begin
         if (k == 0) begin
            rst = 1'b0;
            ev_id = D_ID; ev_fb = D_FB; ev_od = D_OD; ev_loss = 8'd0;
            push(t0, "fr_reset_state", K_HOLD);
            push(t0 + 4, "att1_wait", K_WAIT);
            push(t0 + 13, "cfg_ignored_in_wait", K_WAIT);
            push(t0 + 23, "att1_last_wait", K_WAIT);
            push(t0 + 24, "retry_hold", K_HOLD);
            push(t0 + 27, "retry_hold_last", K_HOLD);
            push(t0 + 28, "att2_wait", K_WAIT);
            push(t0 + 47, "att2_last_wait", K_WAIT);
            push(t0 + 48, "fail_entered", K_FAIL);
            push(t0 + 49, "fail_held", K_FAIL);
         end
         if (k == 10) set_cfg(6'h11, 6'h11, 6'h11);
         if (k == 13) cfg_valid = 1'b0;
         if (k == 50) begin
            set_cfg(6'h3E, 6'h3C, 6'h30);
            pll_lock = 1'b1;
            ev_id = 6'h3E; ev_fb = 6'h3C; ev_od = 6'h30;
            push(t0 + 51, "fail_exit_hold", K_HOLD);
            push(t0 + 55, "fail_exit_wait", K_WAIT);
            push(t0 + 63, "fail_exit_not_yet_locked", K_WAIT);
            push(t0 + 64, "fail_exit_locked", K_RUN);
         end
         if (k == 51) cfg_valid = 1'b0;
         while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
            e_at = q_cyc.pop_front(); e_nm = q_nm.pop_front(); e_v = q_val.pop_front();
            got = snap();
            n_total++;
            if (e_at != cyc || got !== e_v)
               $display("FAIL %s cyc=%0d got=%h expected=%h", e_nm, cyc, got, e_v);
            else n_pass++;
         end
         tick();
      end
   endtask

   task automatic test_async_reset();
      int t0; int e_at; string e_nm; outs_t e_v, got;
      t0 = cyc;
      for (int k = 0; k <= 8; k++) begin
         if (k == 0) begin
            set_cfg(6'h2A, 6'h15, 6'h3F);
            ev_id = 6'h2A; ev_fb = 6'h15; ev_od = 6'h3F;
            push(t0 + 1, "ar_hold", K_HOLD);
            push(t0 + 8, "ar_in_stable", K_WAIT);
         end
         if (k == 1) cfg_valid = 1'b0;
         while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
            e_at = q_cyc.pop_front(); e_nm = q_nm.pop_front(); e_v = q_val.pop_front();
            got = snap();
            n_total++;
            if (e_at != cyc || got !== e_v)
               $display("FAIL %s cyc=%0d got=%h expected=%h", e_nm, cyc, got, e_v);
            else n_pass++;
         end
         if (k < 8) tick();
      end
      // Mid-cycle reset: outputs must return to reset values before the next clock edge.
      #3;
      rst = 1'b1;
      #1;
      ev_id = D_ID; ev_fb = D_FB; ev_od = D_OD; ev_loss = 8'd0;
      push(cyc, "async_reset_mid_stable", K_HOLD);
      e_at = q_cyc.pop_front(); e_nm = q_nm.pop_front(); e_v = q_val.pop_front();
      got = snap();
      n_total++;
      if (e_at != cyc || got !== e_v)
         $display("FAIL %s cyc=%0d got=%h expected=%h", e_nm, cyc, got, e_v);
      else n_pass++;
      tick();
   endtask

   initial begin
      test_reset();
      test_lock_acquire();
      test_reconfig();
      test_stable_glitch();
      test_loss_and_cfg();
      test_fail_retry();
      test_async_reset();
      while (q_cyc.size() > 0) begin
         n_total++;
         $display("FAIL %s never compared (due cyc %0d)", q_nm[0], q_cyc[0]);
         q_cyc.pop_front();
         q_nm.pop_front();
         q_val.pop_front();
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule
